ats_eligible_frame_release: RTL and testbench

//  Consumer end of the ATS eligibility path: accepts per-frame eligibility results
//  (eligible time, discard flag, frame descriptor) from the eligibility calculator and

---
 rtl/ats_pkg.sv | 27 ++
 rtl/ats_desc_fifo.sv | 60 ++++++
 rtl/ats_eligible_frame_release.sv | 184 ++++++++++++++++++
 tb/tb_ats_eligible_frame_release.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ats_pkg.sv
// ats_pkg: definitions shared by the ATS eligibility path.
//   ATS_TS_WIDTH      default eligible/current time width, ps
//   ST_IDLE/WAIT/PRESENT  release FSM state encodings
//   ats_time_diff     (now - t) mod 2^TS
//   ats_time_reached  wrap-aware "now >= t", valid while |now - t| < 2^(TS-1)
package ats_pkg;

  localparam int unsigned ATS_TS_WIDTH = 59;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  typedef logic [ATS_TS_WIDTH-1:0] ats_time_t;

  function automatic ats_time_t ats_time_diff(ats_time_t now, ats_time_t t);
    return now - t;
  endfunction

  // Non-negative modular distance (MSB clear, includes zero) means t has been reached.
  function automatic logic ats_time_reached(ats_time_t now, ats_time_t t);
    ats_time_t d;
    d = now - t;
    return ~d[ATS_TS_WIDTH-1];
  endfunction

endpackage

// File: rtl/ats_desc_fifo.sv
// ats_desc_fifo: synchronous FIFO with a registered head output.
//   clk, reset   clock, synchronous active-high reset
//   wr_en_i      push wr_data_i (caller never pushes when full)
//   rd_en_i      pop head (caller never pops when empty)
//   rd_data_o    registered head entry; valid the cycle after it becomes head
//   count_o      entries currently stored
module ats_desc_fifo #(
  parameter int unsigned WIDTH = 91,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AddrW'(wr_en_i);
    rd_ptr_d = rd_ptr_q + AddrW'(rd_en_i);
    count_d  = count_q + CntW'(wr_en_i) - CntW'(rd_en_i);
    // The slot being written becomes head only when the FIFO is otherwise empty
    // after this cycle's pop; forward the write data so the head is ready next cycle.
    head_d   = (wr_en_i && (wr_ptr_q == rd_ptr_d)) ? wr_data_i : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign rd_data_o = head_q;
  assign count_o   = count_q;

endmodule

// File: rtl/ats_eligible_frame_release.sv
// ats_eligible_frame_release: holds ATS eligibility results in a FIFO and releases each
// frame, in arrival order, once current_time_i reaches its eligible time.
//   clk, reset        clock, synchronous active-high reset
//   current_time_i    free-running local time, ps
//   in_*_i            one-cycle eligibility strobe (no backpressure)
//   out_valid_o/out_ready_i/out_desc_o/out_eligible_o  release handshake
//   fill_level_o      queued entries
//   discard_cnt_o     discard strobes seen (saturating)
//   overflow_cnt_o    strobes dropped because the FIFO was full (saturating)
// Build option ATS_MAX_RESIDENCE_EN adds max_residence_time_i and late_drop_cnt_o:
// a head that is already later than max_residence_time_i when tested in WAIT is
// dropped instead of presented.
module ats_eligible_frame_release
  import ats_pkg::*;
#(
  parameter int unsigned TIMESTAMP_WIDTH = ATS_TS_WIDTH,
  parameter int unsigned DESC_WIDTH      = 32,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned CNT_WIDTH       = 16,
  localparam int unsigned FillW          = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TIMESTAMP_WIDTH-1:0] current_time_i,
  input  logic                       in_valid_i,
  input  logic                       in_discard_i,
  input  logic [TIMESTAMP_WIDTH-1:0] in_eligible_i,
  input  logic [DESC_WIDTH-1:0]      in_desc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DESC_WIDTH-1:0]      out_desc_o,
  output logic [TIMESTAMP_WIDTH-1:0] out_eligible_o,
  output logic [FillW-1:0]           fill_level_o,
  output logic [CNT_WIDTH-1:0]       discard_cnt_o,
`ifdef ATS_MAX_RESIDENCE_EN
  input  logic [TIMESTAMP_WIDTH-1:0] max_residence_time_i,
  output logic [CNT_WIDTH-1:0]       late_drop_cnt_o,
`endif
  output logic [CNT_WIDTH-1:0]       overflow_cnt_o
);

  localparam int unsigned EntryW = TIMESTAMP_WIDTH + DESC_WIDTH;

  // The shared compare helpers are fixed at the package width.
  if (TIMESTAMP_WIDTH != ATS_TS_WIDTH) begin : g_bad_ts_width
    $error("TIMESTAMP_WIDTH must equal ats_pkg::ATS_TS_WIDTH");
  end

  logic [1:0]                 state_q, state_d;
  logic                       out_valid_q, out_valid_d;
  logic [DESC_WIDTH-1:0]      out_desc_q, out_desc_d;
  logic [TIMESTAMP_WIDTH-1:0] out_eligible_q, out_eligible_d;
  logic [CNT_WIDTH-1:0]       discard_cnt_q, discard_cnt_d;
  logic [CNT_WIDTH-1:0]       overflow_cnt_q, overflow_cnt_d;

  logic                       push, pop, full, more_after_pop, head_due, head_late;
  logic [FillW-1:0]           fill;
  logic [EntryW-1:0]          head;
  logic [TIMESTAMP_WIDTH-1:0] head_eligible;
  logic [DESC_WIDTH-1:0]      head_desc;

  ats_desc_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_data_i ({in_eligible_i, in_desc_i}),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (fill)
  );

  assign {head_eligible, head_desc} = head;

  // Full uses the pre-cycle level: a same-cycle pop does not make room.
  assign full           = (fill == FillW'(DEPTH));
  assign push           = in_valid_i & ~in_discard_i & ~full;
  assign more_after_pop = push | (fill > FillW'(1));
  assign head_due       = ats_time_reached(current_time_i, head_eligible);

`ifdef ATS_MAX_RESIDENCE_EN
  logic [TIMESTAMP_WIDTH-1:0] head_age;
  logic [CNT_WIDTH-1:0]       late_drop_cnt_q, late_drop_cnt_d;

  assign head_age  = ats_time_diff(current_time_i, head_eligible);
  assign head_late = head_due && (head_age > max_residence_time_i);

  always_comb begin
    late_drop_cnt_d = late_drop_cnt_q;
    if ((state_q == ST_WAIT) && head_late && (late_drop_cnt_q != '1)) begin
      late_drop_cnt_d = late_drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      late_drop_cnt_q <= '0;
    end else begin
      late_drop_cnt_q <= late_drop_cnt_d;
    end
  end

  assign late_drop_cnt_o = late_drop_cnt_q;
`else
  assign head_late = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    out_desc_d     = out_desc_q;
    out_eligible_d = out_eligible_q;
    pop            = 1'b0;
    unique case (state_q)
      // A push into the empty FIFO moves straight to WAIT; the FIFO forwards it to head.
      ST_IDLE: begin
        if ((fill != '0) || push) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (head_late) begin
          pop     = 1'b1;
          state_d = more_after_pop ? ST_WAIT : ST_IDLE;
        end else if (head_due) begin
          state_d        = ST_PRESENT;
          out_valid_d    = 1'b1;
          out_desc_d     = head_desc;
          out_eligible_d = head_eligible;
        end
      end
      ST_PRESENT: begin
        if (out_ready_i) begin
          pop         = 1'b1;
          out_valid_d = 1'b0;
          state_d     = more_after_pop ? ST_WAIT : ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    discard_cnt_d  = discard_cnt_q;
    overflow_cnt_d = overflow_cnt_q;
    if (in_valid_i && in_discard_i && (discard_cnt_q != '1)) begin
      discard_cnt_d = discard_cnt_q + 1'b1;
    end
    if (in_valid_i && !in_discard_i && full && (overflow_cnt_q != '1)) begin
      overflow_cnt_d = overflow_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      out_valid_q    <= 1'b0;
      out_desc_q     <= '0;
      out_eligible_q <= '0;
      discard_cnt_q  <= '0;
      overflow_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_desc_q     <= out_desc_d;
      out_eligible_q <= out_eligible_d;
      discard_cnt_q  <= discard_cnt_d;
      overflow_cnt_q <= overflow_cnt_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_desc_o     = out_desc_q;
  assign out_eligible_o = out_eligible_q;
  assign fill_level_o   = fill;
  assign discard_cnt_o  = discard_cnt_q;
  assign overflow_cnt_o = overflow_cnt_q;

endmodule

// File: tb/tb_ats_eligible_frame_release.sv
// Scoreboard bench for ats_eligible_frame_release: strobes push the expected released
// frame into a queue; a negedge monitor pops and compares on every handshake.
module tb_ats_eligible_frame_release;

  localparam int unsigned TS    = 59;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 16;
  localparam int unsigned FW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [TS-1:0] cur_time;
  logic          in_valid, in_discard, out_ready, out_valid;
  logic [TS-1:0] in_eligible, out_eligible;
  logic [DW-1:0] in_desc, out_desc;
  logic [FW-1:0] fill_level;
  logic [CW-1:0] discard_cnt, overflow_cnt;
`ifdef ATS_MAX_RESIDENCE_EN
  logic [TS-1:0] max_res;
  logic [CW-1:0] late_drop_cnt;
`endif

  always #5 clk = ~clk;

  ats_eligible_frame_release #(
    .TIMESTAMP_WIDTH (TS),
    .DESC_WIDTH      (DW),
    .DEPTH           (DEPTH),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .current_time_i       (cur_time),
    .in_valid_i           (in_valid),
    .in_discard_i         (in_discard),
    .in_eligible_i        (in_eligible),
    .in_desc_i            (in_desc),
    .out_valid_o          (out_valid),
    .out_ready_i          (out_ready),
    .out_desc_o           (out_desc),
    .out_eligible_o       (out_eligible),
    .fill_level_o         (fill_level),
    .discard_cnt_o        (discard_cnt),
`ifdef ATS_MAX_RESIDENCE_EN
    .max_residence_time_i (max_res),
    .late_drop_cnt_o      (late_drop_cnt),
`endif
    .overflow_cnt_o       (overflow_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] desc;
    logic [TS-1:0] elig;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;
  int   m_fill = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted frame must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_frame", {32'd0, out_desc}, 64'hdead);
      end else begin
        mon_e = sb.pop_front();
        check("sb_desc", {32'd0, out_desc}, {32'd0, mon_e.desc});
        check("sb_elig", {5'd0, out_eligible}, {5'd0, mon_e.elig});
        m_fill--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cur_time = cur_time + 59'd10;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_discard = 1'b0;
    out_ready  = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    sb.delete();
    m_fill = 0;
  endtask

  task automatic strobe(input logic disc, input logic [TS-1:0] el, input logic [DW-1:0] ds,
                        input logic present);
    exp_t e;
    in_valid    = 1'b1;
    in_discard  = disc;
    in_eligible = el;
    in_desc     = ds;
    if (!disc && m_fill < int'(DEPTH)) begin
      m_fill++;
      e.desc = ds;
      e.elig = el;
      if (present) sb.push_back(e);
    end
    tick();
    in_valid   = 1'b0;
    in_discard = 1'b0;
  endtask

  // t_seen is the time during the cycle whose compare raised out_valid.
  task automatic wait_valid(input int budget, output logic [TS-1:0] t_seen, output logic ok);
    ok     = 1'b0;
    t_seen = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      t_seen = cur_time;
      tick();
      if (out_valid) ok = 1'b1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget && (sb.size() != 0 || fill_level != '0); i++) tick();
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({name, "_fill_zero"}, {59'd0, fill_level}, 64'd0);
  endtask

  logic [TS-1:0] t_seen;
  logic          ok;
  int            changes;

  initial begin
    cur_time    = 59'd0;
    in_eligible = '0;
    in_desc     = '0;
`ifdef ATS_MAX_RESIDENCE_EN
    max_res     = 59'd50;
`endif
    do_reset();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_desc", {32'd0, out_desc}, 64'd0);
    check("rst_out_elig", {5'd0, out_eligible}, 64'd0);
    check("rst_fill", {59'd0, fill_level}, 64'd0);
    check("rst_discard_cnt", {48'd0, discard_cnt}, 64'd0);
    check("rst_overflow_cnt", {48'd0, overflow_cnt}, 64'd0);

    // 1: already-eligible frame appears two cycles after its strobe.
    cur_time  = 59'd1000;
    out_ready = 1'b1;
    strobe(1'b0, 59'd900, 32'hA1, 1'b1);
    check("t1_valid_n1", {63'd0, out_valid}, 64'd0);
    tick();
    check("t1_valid_n2", {63'd0, out_valid}, 64'd1);
    check("t1_desc", {32'd0, out_desc}, 64'hA1);
    drain("t1", 10);

    // 2: future frame rises the cycle after the first compare at time >= 1500.
    do_reset();
    cur_time  = 59'd1000;
    out_ready = 1'b1;
    strobe(1'b0, 59'd1500, 32'hB2, 1'b1);
    wait_valid(100, t_seen, ok);
    check("t2_rose", {63'd0, ok}, 64'd1);
    check("t2_rise_time", {5'd0, t_seen}, 64'd1500);
    drain("t2", 10);

    // 3: three frames held behind out_ready=0, then released in order.
    do_reset();
    cur_time = 59'd50;
    strobe(1'b0, 59'd100, 32'hA3, 1'b1);
    strobe(1'b0, 59'd200, 32'hB3, 1'b1);
    strobe(1'b0, 59'd300, 32'hC3, 1'b1);
    check("t3_fill3", {59'd0, fill_level}, 64'd3);
    changes = 0;
    for (int i = 0; i < 60 && cur_time < 59'd400; i++) begin
      tick();
      if (out_valid && out_desc != 32'hA3) changes++;
    end
    check("t3_held_stable", 64'(changes), 64'd0);
    check("t3_valid_at_400", {63'd0, out_valid}, 64'd1);
    check("t3_desc_at_400", {32'd0, out_desc}, 64'hA3);
    check("t3_elig_at_400", {5'd0, out_eligible}, 64'd100);
    check("t3_fill_at_400", {59'd0, fill_level}, 64'd3);
    drain("t3", 20);

    // 4: overflow at full, discards never written.
    do_reset();
    cur_time = 59'd1000;
    for (int i = 0; i < 17; i++) strobe(1'b0, 59'd0, 32'h400 + 32'(i), 1'b1);
    check("t4_fill_full", {59'd0, fill_level}, 64'd16);
    check("t4_overflow", {48'd0, overflow_cnt}, 64'd1);
    strobe(1'b1, 59'd0, 32'hDD, 1'b0);
    strobe(1'b1, 59'd0, 32'hDE, 1'b0);
    check("t4_discard", {48'd0, discard_cnt}, 64'd2);
    check("t4_fill_after_discard", {59'd0, fill_level}, 64'd16);
    check("t4_overflow_after_discard", {48'd0, overflow_cnt}, 64'd1);
    drain("t4", 60);

    // 5: eligible time past the wrap point is not released early.
    do_reset();
    cur_time  = '1;
    cur_time  = cur_time - 59'd39;
    out_ready = 1'b1;
    strobe(1'b0, 59'd5, 32'h55, 1'b1);
    wait_valid(20, t_seen, ok);
    check("t5_rose", {63'd0, ok}, 64'd1);
    check("t5_rise_time", {5'd0, t_seen}, 64'd10);
    drain("t5", 10);

    // 7: write and pop in the same cycle leave fill_level unchanged.
    do_reset();
    cur_time = 59'd1000;
    strobe(1'b0, 59'd0, 32'h71, 1'b1);
    tick();
    tick();
    check("t7_presented", {63'd0, out_valid}, 64'd1);
    check("t7_fill_before", {59'd0, fill_level}, 64'd1);
    out_ready = 1'b1;
    strobe(1'b0, 59'd0, 32'h72, 1'b1);
    check("t7_fill_after", {59'd0, fill_level}, 64'd1);
    drain("t7", 10);

`ifdef ATS_MAX_RESIDENCE_EN
    // 6: blocked head ages the next one past max residence; reset drops PRESENT.
    do_reset();
    cur_time = 59'd100;
    strobe(1'b0, 59'd100, 32'hA6, 1'b1);
    strobe(1'b0, 59'd110, 32'hB6, 1'b0);
    for (int i = 0; i < 20 && cur_time < 59'd200; i++) tick();
    check("t6_a_presented", {32'd0, out_desc}, 64'hA6);
    drain("t6", 10);
    check("t6_late_drop", {48'd0, late_drop_cnt}, 64'd1);
    out_ready = 1'b0;
    strobe(1'b0, 59'd0, 32'hC6, 1'b0);
    tick();
    tick();
    check("t6_c_presented", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    tick();
    check("t6_reset_valid", {63'd0, out_valid}, 64'd0);
    check("t6_reset_fill", {59'd0, fill_level}, 64'd0);
    reset = 1'b0;
    sb.delete();
    m_fill = 0;
`endif

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
